// File: rtl/fir_result_buffer_if.sv
// fir_result_buffer_if: FIR result input, flag control and valid/ready output bus.
// o_sat_count exists only when FIR_SAT_CNT_EN is defined.
interface fir_result_buffer_if #(
    parameter int IN_W  = 31,
    parameter int OUT_W = 16,
    parameter int DEPTH = 8
) ();
    logic signed [IN_W-1:0]       i_result;
    logic                         i_data_valid;
    logic                         i_clr_ovf;
    logic signed [OUT_W-1:0]      o_data;
    logic                         o_valid;
    logic                         i_ready;
    logic [$clog2(DEPTH):0]       o_level;
    logic                         o_overflow;
`ifdef FIR_SAT_CNT_EN
    logic [15:0]                  o_sat_count;
`endif

    modport master (
        output i_result,
        output i_data_valid,
        output i_clr_ovf,
        output i_ready,
        input  o_data,
        input  o_valid,
        input  o_level,
        input  o_overflow
`ifdef FIR_SAT_CNT_EN
        ,
        input  o_sat_count
`endif
    );

    modport slave (
        input  i_result,
        input  i_data_valid,
        input  i_clr_ovf,
        input  i_ready,
        output o_data,
        output o_valid,
        output o_level,
        output o_overflow
`ifdef FIR_SAT_CNT_EN
        ,
        output o_sat_count
`endif
    );
endinterface

// File: rtl/fir_result_buffer.sv
// fir_result_buffer: round/shift/saturate FIR results into a show-ahead FIFO.
// Optional FIR_SAT_CNT_EN adds a saturating count of clipped results.
module fir_result_buffer #(
    parameter int IN_W  = 31,
    parameter int OUT_W = 16,
    parameter int SHIFT = 12,
    parameter int DEPTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    fir_result_buffer_if.slave bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [IN_W:0] ONE = {{IN_W{1'b0}}, 1'b1};
    localparam logic signed [IN_W:0] RND =
        (SHIFT > 0) ? (ONE << RSH) : '0;
    localparam logic signed [IN_W:0] MAXV =
        {{(IN_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [IN_W:0] MINV =
        {{(IN_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic signed [IN_W:0]   ext;
    logic signed [IN_W:0]   t;
    logic signed [IN_W:0]   s;
    logic                   sat_hi;
    logic                   sat_lo;
    logic [OUT_W-1:0]       s_clip;

    logic                   s1_valid;
    logic [OUT_W-1:0]       s1_data;

    logic [OUT_W-1:0]       mem [DEPTH];
    logic [AW-1:0]          wptr;
    logic [AW-1:0]          rptr;
    logic [LW-1:0]          level;
    logic [LW-1:0]          level_nxt;
    logic                   ovf;

    logic                   empty;
    logic                   full;
    logic                   pop;
    logic                   wr_en;
    logic                   drop;

    // Rescale: widen by one bit so the rounding add cannot wrap, then clip.
    always_comb begin
        ext    = {bus.i_result[IN_W-1], bus.i_result};
        t      = ext + RND;
        s      = t >>> SHIFT;
        sat_hi = (s > MAXV);
        sat_lo = (s < MINV);
        s_clip = s[OUT_W-1:0];
        if (sat_hi) begin
            s_clip = MAXV[OUT_W-1:0];
        end else if (sat_lo) begin
            s_clip = MINV[OUT_W-1:0];
        end
    end

    // Stage-1 register holding one rescaled result in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= bus.i_data_valid;
            if (bus.i_data_valid) begin
                s1_data <= s_clip;
            end
        end
    end

    // Occupancy decode: a full FIFO still accepts a push when it also pops.
    always_comb begin
        empty     = (level == '0);
        full      = (level == FULL_LVL);
        pop       = !empty && bus.i_ready;
        wr_en     = s1_valid && (!full || pop);
        drop      = s1_valid && full && !pop;
        level_nxt = level;
        case ({wr_en, pop})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge i_clk) begin
        if (!i_rst && wr_en) begin
            mem[wptr] <= s1_data;
        end
    end

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            level <= level_nxt;
        end
    end

    // Sticky overflow: a drop outranks a simultaneous clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (bus.i_clr_ovf) begin
            ovf <= 1'b0;
        end
    end

`ifdef FIR_SAT_CNT_EN
    logic [15:0] sat_cnt;

    // Count clipped stage-1 results, holding at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_clr_ovf) begin
            sat_cnt <= '0;
        end else if (bus.i_data_valid && (sat_hi || sat_lo)
                     && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end

    assign bus.o_sat_count = sat_cnt;
`endif

    assign bus.o_valid    = !empty;
    assign bus.o_data     = empty ? '0 : mem[rptr];
    assign bus.o_level    = level;
    assign bus.o_overflow = ovf;

endmodule
